afifo_rd_stream: RTL and testbench

//  Read-side front end for a non-show-ahead FIFO read port with fixed read latency.

---
 rtl/afifo_rd_stream.sv | 107 ++++++++++
 tb/tb_afifo_rd_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_stream.sv
// Read-side stream adapter for a non-show-ahead FIFO port with fixed read latency.
// Prefetches into a small ring buffer and presents a valid/ready stream at 1 word/clock.
module afifo_rd_stream #(
  parameter int unsigned WIDTH_DATA = 36,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BUF_DEPTH  = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  rdclock,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_ren,
  input  logic [WIDTH_DATA-1:0] fifo_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_DATA-1:0] out_data,
  input  logic                  flush,
  output logic                  busy,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IFL_W = $clog2(RD_LATENCY + 1);
  localparam int unsigned SUM_W = $clog2(BUF_DEPTH + RD_LATENCY + 1);

  logic [WIDTH_DATA-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr, rd_ptr_nxt;
  logic [OCC_W-1:0]      buf_cnt, buf_cnt_nxt;
  logic [RD_LATENCY-1:0] pipe, pipe_nxt;
  logic [CNT_W-1:0]      word_cnt_nxt;
  logic [IFL_W-1:0]      inflight_cnt;
  logic                  active;
  logic                  capture;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Number of reads issued whose data has not yet been captured
  always_comb begin
    inflight_cnt = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + IFL_W'(pipe[i]);
    end
  end

  // Issue only when every outstanding word is guaranteed a buffer slot
  always_comb begin
    fifo_ren = active && !fifo_empty && !flush &&
               ((SUM_W'(buf_cnt) + SUM_W'(inflight_cnt)) < SUM_W'(BUF_DEPTH));
    out_valid = (buf_cnt != '0);
    out_data  = mem[rd_ptr];
    busy      = (inflight_cnt != '0) || (buf_cnt != '0);
    capture   = pipe[RD_LATENCY-1];
    pop       = out_valid && out_ready;
  end

  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    buf_cnt_nxt  = buf_cnt;
    pipe_nxt     = (pipe << 1) | RD_LATENCY'(fifo_ren);
    word_cnt_nxt = pop ? word_cnt + CNT_W'(1) : word_cnt;
    if (capture) wr_ptr_nxt = ptr_inc(wr_ptr);
    if (pop)     rd_ptr_nxt = ptr_inc(rd_ptr);
    case ({capture, pop})
      2'b10:   buf_cnt_nxt = buf_cnt + OCC_W'(1);
      2'b01:   buf_cnt_nxt = buf_cnt - OCC_W'(1);
      default: buf_cnt_nxt = buf_cnt;
    endcase
    // Flush drops buffered words and anything still returning from the RAM
    if (flush) begin
      wr_ptr_nxt  = '0;
      rd_ptr_nxt  = '0;
      buf_cnt_nxt = '0;
      pipe_nxt    = '0;
    end
  end

  always_ff @(posedge rdclock or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      active   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      buf_cnt  <= '0;
      pipe     <= '0;
      word_cnt <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      active   <= 1'b1;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      buf_cnt  <= buf_cnt_nxt;
      pipe     <= pipe_nxt;
      word_cnt <= word_cnt_nxt;
      if (capture && !flush) begin
        mem[wr_ptr] <= fifo_rdata;
      end
    end
  end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench for afifo_rd_stream: FIFO read-port model feeding two instances
// (latency 1 / depth 3 and latency 2 / depth 4 with a 4-bit counter).
module tb_afifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  fe = 2'b00;
  logic [1:0]  ren;
  logic [1:0]  ov;
  logic [1:0]  ordy = 2'b00;
  logic [1:0]  fl = 2'b00;
  logic [1:0]  bsy;
  logic [35:0] rdata0 = 36'hBADBADBAD;
  logic [35:0] rdata1 = 36'hBADBADBAD;
  logic [35:0] od0, od1;
  logic [31:0] wc0;
  logic [3:0]  wc1;

  int          n_chk = 0;
  int          n_fail = 0;
  int          sel = 0;
  int          cyc = 0;
  int          delivered = 0;
  bit          gap_en = 1'b0;
  logic [35:0] src_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] dp [2][2];
  logic        last_ren, last_ov, last_pop;
  logic [35:0] last_od;
  int          last_cyc;

  always #5 clk = ~clk;

  afifo_rd_stream #(.WIDTH_DATA(36), .RD_LATENCY(1), .BUF_DEPTH(3), .CNT_W(32)) u_lat1 (
    .rdclock(clk), .rd_rst_n(rst_n), .fifo_empty(fe[0]), .fifo_ren(ren[0]),
    .fifo_rdata(rdata0), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
    .flush(fl[0]), .busy(bsy[0]), .word_cnt(wc0));

  afifo_rd_stream #(.WIDTH_DATA(36), .RD_LATENCY(2), .BUF_DEPTH(4), .CNT_W(4)) u_lat2 (
    .rdclock(clk), .rd_rst_n(rst_n), .fifo_empty(fe[1]), .fifo_ren(ren[1]),
    .fifo_rdata(rdata1), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1),
    .flush(fl[1]), .busy(bsy[1]), .word_cnt(wc1));

  // One clock of the FIFO model plus scoreboard monitor for the selected instance
  task automatic step();
    logic        r, p;
    logic [35:0] w, got, e;
    @(negedge clk);
    r   = ren[sel];
    p   = ov[sel] & ordy[sel];
    got = (sel == 1) ? od1 : od0;
    n_chk++;
    if (r && fe[sel]) begin
      n_fail++;
      $display("FAIL ren_while_empty cyc=%0d ren=%b required 0", cyc, r);
    end
    if (fl[sel]) begin
      n_chk++;
      if (r !== 1'b0) begin
        n_fail++;
        $display("FAIL ren_in_flush cyc=%0d ren=%b required 0", cyc, r);
      end
    end
    if (p) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_word cyc=%0d got=%h required no word", cyc, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL stream_data cyc=%0d got=%h required %h", cyc, got, e);
        end
      end
      delivered++;
    end
    w = 36'hBADBADBAD;
    if (r) begin
      if (src_q.size() != 0) w = src_q.pop_front();
      exp_q.push_back(w);
    end
    if (fl[sel]) exp_q.delete();
    last_ren = r;
    last_ov  = ov[sel];
    last_pop = p;
    last_od  = got;
    last_cyc = cyc;
    @(posedge clk);
    #1;
    dp[sel][1] = dp[sel][0];
    dp[sel][0] = r ? w : 36'hBADBADBAD;
    if (sel == 1) rdata1 = dp[1][1];
    else          rdata0 = dp[0][0];
    fe[sel] = (src_q.size() == 0) || (gap_en && ((cyc / 3) % 2 == 1));
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fe    = 2'b00;
    ordy  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk += 5;
      if (ren !== 2'b00) begin n_fail++; $display("FAIL reset_ren got=%b required 00", ren); end
      if (ov !== 2'b00) begin n_fail++; $display("FAIL reset_valid got=%b required 00", ov); end
      if (bsy !== 2'b00) begin n_fail++; $display("FAIL reset_busy got=%b required 00", bsy); end
      if (wc0 !== 32'd0 || wc1 !== 4'd0) begin
        n_fail++; $display("FAIL reset_word_cnt got=%0d/%0d required 0/0", wc0, wc1);
      end
      if (od0 !== 36'd0 || od1 !== 36'd0) begin
        n_fail++; $display("FAIL reset_data got=%h/%h required 0/0", od0, od1);
      end
    end
    @(posedge clk);
    #1;
    fe    = 2'b11;
    ordy  = 2'b00;
    rst_n = 1'b1;
    sel   = 0;
    step();
    step();
  endtask

  task automatic test_stream();
    int first_ren = -1, first_ov = -1, first_pop = -1, last_pop_c = -1, npops = 0;
    sel = 0;
    for (int i = 1; i <= 16; i++) src_q.push_back(36'(i));
    fe[0]   = 1'b0;
    ordy[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (last_ren && first_ren < 0) first_ren = last_cyc;
      if (last_ov && first_ov < 0) first_ov = last_cyc;
      if (last_pop) begin
        if (first_pop < 0) first_pop = last_cyc;
        last_pop_c = last_cyc;
        npops++;
      end
    end
    n_chk += 5;
    if (first_ren < 0 || first_ov - first_ren != 2) begin
      n_fail++; $display("FAIL stream_latency got=%0d required 2", first_ov - first_ren);
    end
    if (npops != 16) begin n_fail++; $display("FAIL stream_count got=%0d required 16", npops); end
    if (last_pop_c - first_pop != 15) begin
      n_fail++; $display("FAIL stream_full_rate span=%0d required 15", last_pop_c - first_pop);
    end
    if (wc0 !== 32'd16) begin n_fail++; $display("FAIL stream_word_cnt got=%0d required 16", wc0); end
    if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL stream_idle_busy got=%b required 0", bsy[0]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] wc_start;
    logic [35:0] stall_od;
    sel = 0;
    delivered = 0;
    wc_start = wc0;
    stall_od = '0;
    for (int i = 0; i < 20; i++) src_q.push_back(36'h100 + 36'(i));
    fe[0]   = 1'b0;
    ordy[0] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ordy[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) stall_od = last_od;
      n_chk++;
      if (last_ov !== 1'b1 || last_od !== stall_od) begin
        n_fail++; $display("FAIL bp_data_stable i=%0d got=%h required %h", i, last_od, stall_od);
      end
      if (i >= 3) begin
        n_chk++;
        if (last_ren !== 1'b0) begin
          n_fail++; $display("FAIL bp_ren_stop i=%0d got=%b required 0", i, last_ren);
        end
      end
    end
    n_chk++;
    if (exp_q.size() != 3) begin
      n_fail++; $display("FAIL bp_held_words got=%0d required 3", exp_q.size());
    end
    ordy[0] = 1'b1;
    for (int i = 0; i < 60 && (src_q.size() != 0 || exp_q.size() != 0); i++) step();
    n_chk += 2;
    if (delivered != 20) begin n_fail++; $display("FAIL bp_delivered got=%0d required 20", delivered); end
    if (wc0 - wc_start !== 32'd20) begin
      n_fail++; $display("FAIL bp_word_cnt got=%0d required 20", wc0 - wc_start);
    end
  endtask

  task automatic test_empty_gaps();
    sel = 0;
    delivered = 0;
    gap_en = 1'b1;
    for (int i = 0; i < 16; i++) src_q.push_back(36'h200 + 36'(i));
    fe[0]   = 1'b0;
    ordy[0] = 1'b1;
    for (int i = 0; i < 200 && (src_q.size() != 0 || exp_q.size() != 0); i++) step();
    gap_en = 1'b0;
    n_chk++;
    if (delivered != 16) begin n_fail++; $display("FAIL gaps_delivered got=%0d required 16", delivered); end
    step();
  endtask

  task automatic test_flush();
    logic [31:0] wc_start;
    sel = 0;
    delivered = 0;
    wc_start = wc0;
    for (int i = 0; i < 10; i++) src_q.push_back(36'h300 + 36'(i));
    fe[0]   = 1'b0;
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_chk += 2;
    if (ov[0] !== 1'b1 || bsy[0] !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_state got=%b%b required 11", ov[0], bsy[0]);
    end
    if (exp_q.size() != 3) begin
      n_fail++; $display("FAIL flush_pre_outstanding got=%0d required 3", exp_q.size());
    end
    fl[0]   = 1'b1;
    ordy[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    n_chk += 2;
    if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b required 0", ov[0]); end
    if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL flush_busy got=%b required 0", bsy[0]); end
    for (int i = 0; i < 3; i++) step();
    fl[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    n_chk++;
    if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL flush2_valid got=%b required 0", ov[0]); end
    for (int i = 0; i < 60 && (src_q.size() != 0 || exp_q.size() != 0); i++) step();
    n_chk += 2;
    if (delivered != 7) begin n_fail++; $display("FAIL flush_delivered got=%0d required 7", delivered); end
    if (wc0 - wc_start !== 32'd7) begin
      n_fail++; $display("FAIL flush_word_cnt got=%0d required 7", wc0 - wc_start);
    end
  endtask

  task automatic test_rdlat2();
    int first_ren = -1, first_ov = -1, first_pop = -1, last_pop_c = -1, npops = 0;
    sel = 1;
    delivered = 0;
    ordy[0] = 1'b0;
    for (int i = 0; i < 20; i++) src_q.push_back(36'h400 + 36'(i));
    fe[1]   = 1'b0;
    ordy[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_ren && first_ren < 0) first_ren = last_cyc;
      if (last_ov && first_ov < 0) first_ov = last_cyc;
      if (last_pop) begin
        if (first_pop < 0) first_pop = last_cyc;
        last_pop_c = last_cyc;
        npops++;
      end
    end
    n_chk += 4;
    if (first_ren < 0 || first_ov - first_ren != 3) begin
      n_fail++; $display("FAIL lat2_latency got=%0d required 3", first_ov - first_ren);
    end
    if (npops != 20) begin n_fail++; $display("FAIL lat2_count got=%0d required 20", npops); end
    if (last_pop_c - first_pop != 19) begin
      n_fail++; $display("FAIL lat2_full_rate span=%0d required 19", last_pop_c - first_pop);
    end
    if (wc1 !== 4'd4) begin n_fail++; $display("FAIL lat2_word_cnt_wrap got=%0d required 4", wc1); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      dp[i][0] = 36'hBADBADBAD;
      dp[i][1] = 36'hBADBADBAD;
    end
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_gaps();
    test_flush();
    test_rdlat2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1);
  end

endmodule
